// File: rtl/id_ex_pipe_if.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_if
// Bundle of the ID/EX pipeline register's stage-facing signals.
//   ID side  (master drives) : id_valid, id_* decoder control bits, id_pc4,
//                              id_rdata1/2, id_imm, id_funct, id_rs/rt/rd
//   Control  (master drives) : ex_stall, flush
//   EX side  (slave drives)  : ex_valid, ex_* control bits, ex_pc4,
//                              ex_rdata1/2, ex_imm, ex_funct, ex_rs/rt/rd
//   Hazard   (slave drives)  : id_hold, load_use, bubble_cnt
// The slave modport is used by the pipeline register itself.
// ---------------------------------------------------------------------------
interface id_ex_pipe_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    // ID-stage inputs
    logic              id_valid;
    logic [1:0]        id_aluop;
    logic              id_memread;
    logic              id_memtoreg;
    logic              id_regdst;
    logic              id_branch;
    logic              id_alusrc;
    logic              id_memwrite;
    logic              id_regwrite;
    logic              id_jump;
    logic              id_jumpreg;
    logic [DATA_W-1:0] id_pc4;
    logic [DATA_W-1:0] id_rdata1;
    logic [DATA_W-1:0] id_rdata2;
    logic [DATA_W-1:0] id_imm;
    logic [5:0]        id_funct;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;

    // Pipeline control
    logic              ex_stall;
    logic              flush;

    // EX-stage outputs
    logic              ex_valid;
    logic [1:0]        ex_aluop;
    logic              ex_memread;
    logic              ex_memtoreg;
    logic              ex_regdst;
    logic              ex_branch;
    logic              ex_alusrc;
    logic              ex_memwrite;
    logic              ex_regwrite;
    logic              ex_jump;
    logic              ex_jumpreg;
    logic [DATA_W-1:0] ex_pc4;
    logic [DATA_W-1:0] ex_rdata1;
    logic [DATA_W-1:0] ex_rdata2;
    logic [DATA_W-1:0] ex_imm;
    logic [5:0]        ex_funct;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_rd;

    // Hazard outputs
    logic              id_hold;
    logic              load_use;
    logic [CNT_W-1:0]  bubble_cnt;

    modport master (
        output id_valid, id_aluop, id_memread, id_memtoreg, id_regdst,
               id_branch, id_alusrc, id_memwrite, id_regwrite, id_jump,
               id_jumpreg, id_pc4, id_rdata1, id_rdata2, id_imm, id_funct,
               id_rs, id_rt, id_rd, ex_stall, flush,
        input  ex_valid, ex_aluop, ex_memread, ex_memtoreg, ex_regdst,
               ex_branch, ex_alusrc, ex_memwrite, ex_regwrite, ex_jump,
               ex_jumpreg, ex_pc4, ex_rdata1, ex_rdata2, ex_imm, ex_funct,
               ex_rs, ex_rt, ex_rd, id_hold, load_use, bubble_cnt
    );

    modport slave (
        input  id_valid, id_aluop, id_memread, id_memtoreg, id_regdst,
               id_branch, id_alusrc, id_memwrite, id_regwrite, id_jump,
               id_jumpreg, id_pc4, id_rdata1, id_rdata2, id_imm, id_funct,
               id_rs, id_rt, id_rd, ex_stall, flush,
        output ex_valid, ex_aluop, ex_memread, ex_memtoreg, ex_regdst,
               ex_branch, ex_alusrc, ex_memwrite, ex_regwrite, ex_jump,
               ex_jumpreg, ex_pc4, ex_rdata1, ex_rdata2, ex_imm, ex_funct,
               ex_rs, ex_rt, ex_rd, id_hold, load_use, bubble_cnt
    );
endinterface

// File: rtl/id_ex_pipe.sv
// ---------------------------------------------------------------------------
// id_ex_pipe
// ID/EX pipeline register of the 5-stage MIPS pipeline with load-use hazard
// detection.
//   clk    : pipeline clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : id_ex_pipe_if.slave
//            in  : ID instruction fields + decoder control, ex_stall, flush
//            out : registered EX fields, id_hold, load_use, bubble_cnt
// Edge priority: flush (bubble) > ex_stall (hold) > load-use (bubble and
// count) > normal load. id_hold and load_use are combinational; all ex_*
// fields and bubble_cnt are registered.
// ---------------------------------------------------------------------------
module id_ex_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    id_ex_pipe_if.slave bus
);

    typedef struct packed {
        logic [1:0] aluop;
        logic       memread;
        logic       memtoreg;
        logic       regdst;
        logic       branch;
        logic       alusrc;
        logic       memwrite;
        logic       regwrite;
        logic       jump;
        logic       jumpreg;
    } ctrl_t;

    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_HOLD   = 2'd1,
        ACT_BUBBLE = 2'd2,
        ACT_FLUSH  = 2'd3
    } act_e;

    localparam ctrl_t             CTRL_NOP  = 11'b0;
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
    localparam logic [REG_AW-1:0] REG_ZERO  = {REG_AW{1'b0}};
    localparam logic [5:0]        FUNCT_ZERO = 6'b0;
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    logic              valid_q,  valid_d;
    ctrl_t             ctrl_q,   ctrl_d;
    logic [DATA_W-1:0] pc4_q,    pc4_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic [DATA_W-1:0] rdata2_q, rdata2_d;
    logic [DATA_W-1:0] imm_q,    imm_d;
    logic [5:0]        funct_q,  funct_d;
    logic [REG_AW-1:0] rs_q,     rs_d;
    logic [REG_AW-1:0] rt_q,     rt_d;
    logic [REG_AW-1:0] rd_q,     rd_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;

    ctrl_t             id_ctrl_s;
    logic              load_use_s;
    logic              id_hold_s;
    act_e              act_s;

    // Gather the decoder's control bits into one bundle.
    always_comb begin
        id_ctrl_s.aluop    = bus.id_aluop;
        id_ctrl_s.memread  = bus.id_memread;
        id_ctrl_s.memtoreg = bus.id_memtoreg;
        id_ctrl_s.regdst   = bus.id_regdst;
        id_ctrl_s.branch   = bus.id_branch;
        id_ctrl_s.alusrc   = bus.id_alusrc;
        id_ctrl_s.memwrite = bus.id_memwrite;
        id_ctrl_s.regwrite = bus.id_regwrite;
        id_ctrl_s.jump     = bus.id_jump;
        id_ctrl_s.jumpreg  = bus.id_jumpreg;
    end

    // Load-use detection: both ID source fields are compared regardless of
    // instruction format; a false match on an I-type rt only costs a bubble.
    // $zero never carries a dependency.
    always_comb begin
        load_use_s = valid_q & ctrl_q.memread & (rt_q != REG_ZERO) & bus.id_valid
                   & ((rt_q == bus.id_rs) | (rt_q == bus.id_rt));
        id_hold_s  = ~bus.flush & (bus.ex_stall | load_use_s);
    end

    // Edge action by priority: a redirect squashes even a stalled slot.
    always_comb begin
        act_s = ACT_LOAD;
        if (bus.flush) begin
            act_s = ACT_FLUSH;
        end else if (bus.ex_stall) begin
            act_s = ACT_HOLD;
        end else if (load_use_s) begin
            act_s = ACT_BUBBLE;
        end else begin
            act_s = ACT_LOAD;
        end
    end

    // Next-state values for the stage register and the bubble counter.
    always_comb begin
        valid_d  = valid_q;
        ctrl_d   = ctrl_q;
        pc4_d    = pc4_q;
        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
        imm_d    = imm_q;
        funct_d  = funct_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;

        case (act_s)
            ACT_HOLD: begin
                valid_d = valid_q;
            end
            ACT_LOAD: begin
                // An empty ID slot still moves its data but never its
                // control, so it cannot have architectural effect.
                valid_d  = bus.id_valid;
                ctrl_d   = bus.id_valid ? id_ctrl_s : CTRL_NOP;
                pc4_d    = bus.id_pc4;
                rdata1_d = bus.id_rdata1;
                rdata2_d = bus.id_rdata2;
                imm_d    = bus.id_imm;
                funct_d  = bus.id_funct;
                rs_d     = bus.id_rs;
                rt_d     = bus.id_rt;
                rd_d     = bus.id_rd;
            end
            ACT_BUBBLE, ACT_FLUSH: begin
                valid_d  = 1'b0;
                ctrl_d   = CTRL_NOP;
                pc4_d    = DATA_ZERO;
                rdata1_d = DATA_ZERO;
                rdata2_d = DATA_ZERO;
                imm_d    = DATA_ZERO;
                funct_d  = FUNCT_ZERO;
                rs_d     = REG_ZERO;
                rt_d     = REG_ZERO;
                rd_d     = REG_ZERO;
            end
            default: begin
                valid_d  = 1'b0;
                ctrl_d   = CTRL_NOP;
                pc4_d    = DATA_ZERO;
                rdata1_d = DATA_ZERO;
                rdata2_d = DATA_ZERO;
                imm_d    = DATA_ZERO;
                funct_d  = FUNCT_ZERO;
                rs_d     = REG_ZERO;
                rt_d     = REG_ZERO;
                rd_d     = REG_ZERO;
            end
        endcase

        // Only load-use bubbles are counted; flush bubbles are not.
        if ((act_s == ACT_BUBBLE) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Stage register and bubble counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            ctrl_q   <= CTRL_NOP;
            pc4_q    <= DATA_ZERO;
            rdata1_q <= DATA_ZERO;
            rdata2_q <= DATA_ZERO;
            imm_q    <= DATA_ZERO;
            funct_q  <= FUNCT_ZERO;
            rs_q     <= REG_ZERO;
            rt_q     <= REG_ZERO;
            rd_q     <= REG_ZERO;
            cnt_q    <= CNT_ZERO;
        end else begin
            valid_q  <= valid_d;
            ctrl_q   <= ctrl_d;
            pc4_q    <= pc4_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            imm_q    <= imm_d;
            funct_q  <= funct_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.ex_valid    = valid_q;
    assign bus.ex_aluop    = ctrl_q.aluop;
    assign bus.ex_memread  = ctrl_q.memread;
    assign bus.ex_memtoreg = ctrl_q.memtoreg;
    assign bus.ex_regdst   = ctrl_q.regdst;
    assign bus.ex_branch   = ctrl_q.branch;
    assign bus.ex_alusrc   = ctrl_q.alusrc;
    assign bus.ex_memwrite = ctrl_q.memwrite;
    assign bus.ex_regwrite = ctrl_q.regwrite;
    assign bus.ex_jump     = ctrl_q.jump;
    assign bus.ex_jumpreg  = ctrl_q.jumpreg;
    assign bus.ex_pc4      = pc4_q;
    assign bus.ex_rdata1   = rdata1_q;
    assign bus.ex_rdata2   = rdata2_q;
    assign bus.ex_imm      = imm_q;
    assign bus.ex_funct    = funct_q;
    assign bus.ex_rs       = rs_q;
    assign bus.ex_rt       = rt_q;
    assign bus.ex_rd       = rd_q;
    assign bus.id_hold     = id_hold_s;
    assign bus.load_use    = load_use_s;
    assign bus.bubble_cnt  = cnt_q;

endmodule
